xs_rr_arbiter: RTL and testbench

// - Round-robin arbiter sharing one switch output port between NREQ input requesters.
// - Selects a winner with XF1b (lowest-set-bit isolate, MASK_OUT=0) on two request vectors:
//   - requests above the last-granted index;
//   - all requests, used when none lie above the last grant.
// - Presents a registered one-hot grant to the output mux.
// - Forwards valid/ready between the granted requester and the output port.

---
 rtl/xs_rr_arbiter.sv | 120 ++++++++++++
 tb/tb_xs_rr_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/xs_rr_arbiter.sv
// Round-robin arbiter: shares one output port between NREQ requesters.
// Latency: registered one-hot grant appears 1 cycle after req_vld rises; back-to-back re-grant on every accepted beat.
// Backpressure: out_rdy=0 holds the grant unchanged; req_rdy follows out_rdy for the granted requester only.
// Optional packet lock: define XS_ARB_LOCK_EN to keep the grant until the beat with req_last is accepted.
module xs_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_vld,
  input  logic [NREQ-1:0] req_last,
  output logic [NREQ-1:0] req_rdy,
  input  logic            out_rdy,
  output logic            gnt_vld,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   gnt_idx
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    LOCK  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   gnt_idx_q;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic            accept;

  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};
  localparam logic [IW-1:0]   PTR_RST = IW'(NREQ - 1);

  // Lowest-set-bit isolate: keeps only the least significant 1 of x.
  function automatic logic [NREQ-1:0] xf1b(input logic [NREQ-1:0] x);
    return x & (~x + ONE);
  endfunction

  // Round-robin pick: lowest request strictly above ptr, else wrap to lowest overall.
  function automatic logic [NREQ-1:0] win(input logic [NREQ-1:0] req,
                                          input logic [IW-1:0]   ptr);
    logic [NREQ-1:0] hi;
    hi = '0;
    for (int i = 0; i < NREQ; i++) begin
      hi[i] = req[i] && (i > int'(ptr));
    end
    return (hi != '0) ? xf1b(hi) : xf1b(req);
  endfunction

  // One-hot to binary; zero vector maps to index 0.
  function automatic logic [IW-1:0] oh2idx(input logic [NREQ-1:0] oh);
    logic [IW-1:0] idx;
    idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (oh[i]) idx = idx | IW'(i);
    end
    return idx;
  endfunction

`ifndef XS_ARB_LOCK_EN
  // req_last only matters when packet lock is compiled in.
  logic unused_req_last;
  assign unused_req_last = ^req_last;
`endif

  assign gnt_vld = (state_q != IDLE);
  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign accept  = gnt_vld && out_rdy && req_vld[gnt_idx_q];
  assign req_rdy = gnt_vld ? (gnt_q & {NREQ{out_rdy}}) : '0;

  // Next-state: first grant from IDLE, re-arbitrate on every accepted beat (unless locked mid-packet).
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (req_vld != '0) begin
          gnt_d   = win(req_vld, ptr_q);
          state_d = GRANT;
        end
      end
      default: begin
        if (accept) begin
`ifdef XS_ARB_LOCK_EN
          if (!req_last[gnt_idx_q]) begin
            state_d = LOCK;
          end else begin
            ptr_d   = gnt_idx_q;
            gnt_d   = win(req_vld, gnt_idx_q);
            state_d = (gnt_d != '0) ? GRANT : IDLE;
          end
`else
          ptr_d   = gnt_idx_q;
          gnt_d   = win(req_vld, gnt_idx_q);
          state_d = (gnt_d != '0) ? GRANT : IDLE;
`endif
        end
      end
    endcase
  end

  // State, grant and pointer registers; reset parks ptr at the top so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      ptr_q     <= PTR_RST;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= oh2idx(gnt_d);
      ptr_q     <= ptr_d;
    end
  end

endmodule

// File: tb/tb_xs_rr_arbiter.sv
// Directed bench for xs_rr_arbiter with NREQ=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Prints one summary line with the check and error counts.
module tb_xs_rr_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req_vld;
  logic [3:0] req_last;
  logic [3:0] req_rdy;
  logic       out_rdy;
  logic       gnt_vld;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;

  int checks;
  int errors;

  xs_rr_arbiter #(.NREQ(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_vld  (req_vld),
    .req_last (req_last),
    .req_rdy  (req_rdy),
    .out_rdy  (out_rdy),
    .gnt_vld  (gnt_vld),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Grant state check: gnt, gnt_idx and gnt_vld together.
  task automatic chk_gnt(input string tag, input logic [3:0] eg, input logic [1:0] ei,
                         input logic ev);
    chk({tag, ".gnt"}, {4'b0, gnt}, {4'b0, eg});
    chk({tag, ".idx"}, {6'b0, gnt_idx}, {6'b0, ei});
    chk({tag, ".vld"}, {7'b0, gnt_vld}, {7'b0, ev});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    req_vld  = 4'b1111;
    req_last = 4'b0000;
    out_rdy  = 1'b1;

    // Reset held 2 cycles with all requests active: nothing granted.
    step();
    chk_gnt("rst1", 4'b0000, 2'd0, 1'b0);
    chk("rst1.rdy", {4'b0, req_rdy}, 8'h00);
    step();
    chk_gnt("rst2", 4'b0000, 2'd0, 1'b0);
    chk("rst2.rdy", {4'b0, req_rdy}, 8'h00);
    rst = 1'b0;

    // All requesting, out_rdy=1: rotate 0,1,2,3,0.
    step();
    chk_gnt("rr0", 4'b0001, 2'd0, 1'b1);
    chk("rr0.rdy", {4'b0, req_rdy}, 8'b0000_0001);
    step();
    chk_gnt("rr1", 4'b0010, 2'd1, 1'b1);
    step();
    chk_gnt("rr2", 4'b0100, 2'd2, 1'b1);
    step();
    chk_gnt("rr3", 4'b1000, 2'd3, 1'b1);
    step();
    chk_gnt("rr4", 4'b0001, 2'd0, 1'b1);

    // Backpressure: grant holds 3 cycles, then one accept moves to req2.
    do_reset();
    req_vld = 4'b0101;
    out_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_gnt("bp.hold", 4'b0001, 2'd0, 1'b1);
      chk("bp.rdy0", {4'b0, req_rdy}, 8'h00);
    end
    out_rdy = 1'b1;
    #1;
    chk("bp.rdy1", {4'b0, req_rdy}, 8'b0000_0001);
    step();
    chk_gnt("bp.next", 4'b0100, 2'd2, 1'b1);

    // Packet of 3 beats from req0 with req1 also waiting.
    do_reset();
    req_vld  = 4'b0011;
    req_last = 4'b0000;
    out_rdy  = 1'b1;
    step();
    chk_gnt("pk.b1", 4'b0001, 2'd0, 1'b1);
    step();
`ifdef XS_ARB_LOCK_EN
    chk_gnt("pk.b2", 4'b0001, 2'd0, 1'b1);
`else
    chk_gnt("pk.b2", 4'b0010, 2'd1, 1'b1);
`endif
    step();
    chk_gnt("pk.b3", 4'b0001, 2'd0, 1'b1);
    req_last = 4'b0001;
    step();
    chk_gnt("pk.after", 4'b0010, 2'd1, 1'b1);
    req_last = 4'b0000;

    // Reset while req2 holds the grant; pointer returns to the reset position.
    do_reset();
    req_vld = 4'b1111;
    step();
    step();
    step();
    chk_gnt("mr.pre", 4'b0100, 2'd2, 1'b1);
    rst = 1'b1;
    step();
    chk_gnt("mr.rst", 4'b0000, 2'd0, 1'b0);
    chk("mr.rdy", {4'b0, req_rdy}, 8'h00);
    rst     = 1'b0;
    req_vld = 4'b1010;
    step();
    chk_gnt("mr.post", 4'b0010, 2'd1, 1'b1);

    // Single requester 3: re-granted every cycle without a bubble.
    do_reset();
    req_vld = 4'b1000;
    for (int c = 0; c < 3; c++) begin
      step();
      chk_gnt("sg.run", 4'b1000, 2'd3, 1'b1);
      chk("sg.rdy", {4'b0, req_rdy}, 8'b0000_1000);
    end
    // Requester drops: no beat is accepted, and a held grant is never withdrawn.
    req_vld = 4'b0000;
    step();
    chk_gnt("sg.drop", 4'b1000, 2'd3, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
